// File: rtl/trace_capture.sv
// On-chip logic analyser: captures CHANNELS probe words per qualified sample into a
// circular buffer, stops a programmable number of samples after a trigger, then reads back.
module trace_capture #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 64,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_en,
    input  logic [CHANNELS*WIDTH-1:0] probe_data,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [CW-1:0]             trig_ch,
    input  logic [WIDTH-1:0]          trig_value,
    input  logic [WIDTH-1:0]          trig_mask,
    input  logic                      trig_ext,
    input  logic [AW-1:0]             post_count,
    input  logic [AW-1:0]             rd_addr,
    input  logic [CW-1:0]             rd_ch,
    output logic [WIDTH-1:0]          rd_data,
    output logic [1:0]                state,
    output logic                      done,
    output logic [AW:0]               count,
    output logic [AW-1:0]             trig_pos
);

    localparam int unsigned NCH = 1 << CW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]               count_q, count_d;
    logic [AW-1:0]             post_q, post_d;
    logic [AW-1:0]             remain_q, remain_d;
    logic [AW-1:0]             trig_phys_q, trig_phys_d;
    logic [AW-1:0]             start_c, start_d;
    logic [AW-1:0]             rd_phys_c;
    logic                      wr_en;
    logic                      trig_hit;

    logic [CHANNELS*WIDTH-1:0] mem [DEPTH];
    logic [CHANNELS*WIDTH-1:0] rd_word;
    logic [WIDTH-1:0]          probe_ch   [NCH];
    logic [WIDTH-1:0]          rd_word_ch [NCH];
    logic [NCH-1:0]            ch_valid;

    // Split packed probe/memory words into per-channel views; unused select codes read as 0.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        if (c < CHANNELS) begin : g_used
            assign probe_ch[c]   = probe_data[c*WIDTH +: WIDTH];
            assign rd_word_ch[c] = rd_word[c*WIDTH +: WIDTH];
            assign ch_valid[c]   = 1'b1;
        end else begin : g_unused
            assign probe_ch[c]   = '0;
            assign rd_word_ch[c] = '0;
            assign ch_valid[c]   = 1'b0;
        end
    end

    assign trig_hit = sample_en &&
                      (trig_ext ||
                       (ch_valid[trig_ch] && (((probe_ch[trig_ch] ^ trig_value) & trig_mask) == '0)));

    // Oldest sample sits at wr_ptr once the buffer has wrapped.
    assign start_c   = (count_q == (AW+1)'(DEPTH)) ? wr_ptr_q : '0;
    assign rd_phys_c = start_c + rd_addr;
    assign rd_word   = mem[rd_phys_c];

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        remain_d    = remain_q;
        trig_phys_d = trig_phys_q;
        wr_en       = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_d  = S_ARMED;
                        wr_ptr_d = '0;
                        count_d  = '0;
                        post_d   = post_count;
                    end
                end
                S_ARMED: begin
                    if (sample_en) begin
                        wr_en = 1'b1;
                        if (trig_hit) begin
                            trig_phys_d = wr_ptr_q;
                            remain_d    = post_q;
                            state_d     = (post_q == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (sample_en) begin
                        wr_en    = 1'b1;
                        remain_d = remain_q - AW'(1);
                        if (remain_q == AW'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != (AW+1)'(DEPTH)) begin
                count_d = count_q + (AW+1)'(1);
            end
        end
    end

    assign start_d = (count_d == (AW+1)'(DEPTH)) ? wr_ptr_d : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            remain_q    <= '0;
            trig_phys_q <= '0;
            done        <= 1'b0;
            trig_pos    <= '0;
            rd_data     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            remain_q    <= remain_d;
            trig_phys_q <= trig_phys_d;
            done        <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                trig_pos <= trig_phys_d - start_d;
            end
            rd_data     <= ({1'b0, rd_addr} < count_q) ? rd_word_ch[rd_ch] : '0;
        end
    end

    // Capture storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= probe_data;
        end
    end

    assign state = state_q;
    assign count = count_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture (DEPTH=8, CHANNELS=2): stimulus queues expected
// output values, a negedge monitor pops and compares them.
module tb_trace_capture;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned AW       = 3;
    localparam int unsigned CW       = 1;

    localparam int SEL_RD    = 0;
    localparam int SEL_STATE = 1;
    localparam int SEL_DONE  = 2;
    localparam int SEL_COUNT = 3;
    localparam int SEL_TPOS  = 4;

    logic                      clock;
    logic                      reset;
    logic                      sample_en;
    logic [CHANNELS*WIDTH-1:0] probe_data;
    logic                      arm;
    logic                      abort;
    logic [CW-1:0]             trig_ch;
    logic [WIDTH-1:0]          trig_value;
    logic [WIDTH-1:0]          trig_mask;
    logic                      trig_ext;
    logic [AW-1:0]             post_count;
    logic [AW-1:0]             rd_addr;
    logic [CW-1:0]             rd_ch;
    logic [WIDTH-1:0]          rd_data;
    logic [1:0]                state;
    logic                      done;
    logic [AW:0]               count;
    logic [AW-1:0]             trig_pos;

    trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_en  (sample_en),
        .probe_data (probe_data),
        .arm        (arm),
        .abort      (abort),
        .trig_ch    (trig_ch),
        .trig_value (trig_value),
        .trig_mask  (trig_mask),
        .trig_ext   (trig_ext),
        .post_count (post_count),
        .rd_addr    (rd_addr),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .state      (state),
        .done       (done),
        .count      (count),
        .trig_pos   (trig_pos)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        int          due;
    } item_t;

    item_t exp_q[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due against the settled outputs.
    always @(negedge clock) begin
        item_t       it;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            it = exp_q.pop_front();
            case (it.sel)
                SEL_RD:    act = rd_data;
                SEL_STATE: act = 32'(state);
                SEL_DONE:  act = 32'(done);
                SEL_COUNT: act = 32'(count);
                default:   act = 32'(trig_pos);
            endcase
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] v);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = v;
        it.due  = cyc;
        exp_q.push_back(it);
    endtask

    task automatic expect_status(input string tag, input logic [1:0] st, input logic dn,
                                 input logic [AW:0] cnt);
        expect_val({tag, "_state"}, SEL_STATE, 32'(st));
        expect_val({tag, "_done"},  SEL_DONE,  32'(dn));
        expect_val({tag, "_count"}, SEL_COUNT, 32'(cnt));
    endtask

    task automatic sample(input logic [31:0] v, input logic ext);
        probe_data = {32'hA000_0000 | v, v};
        sample_en  = 1'b1;
        trig_ext   = ext;
        tick();
        sample_en  = 1'b0;
        trig_ext   = 1'b0;
    endtask

    task automatic idle_cycle();
        tick();
    endtask

    task automatic do_arm(input logic [31:0] value, input logic [31:0] mask,
                          input logic [AW-1:0] post);
        trig_value = value;
        trig_mask  = mask;
        post_count = post;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic rd(input string name, input logic [AW-1:0] addr, input logic [CW-1:0] ch,
                      input logic [31:0] v);
        rd_addr = addr;
        rd_ch   = ch;
        tick();
        expect_val(name, SEL_RD, v);
    endtask

    initial begin
        reset      = 1'b1;
        sample_en  = 1'b0;
        probe_data = '0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig_ch    = '0;
        trig_value = '0;
        trig_mask  = '0;
        trig_ext   = 1'b0;
        post_count = '0;
        rd_addr    = '0;
        rd_ch      = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        expect_status("reset", 2'd0, 1'b0, 4'd0);
        expect_val("reset_tpos", SEL_TPOS, 32'd0);
        expect_val("reset_rd", SEL_RD, 32'd0);

        // Basic capture: trigger on ch0 == 5, two post samples.
        do_arm(32'd5, 32'hFFFF_FFFF, 3'd2);
        expect_val("t1_armed", SEL_STATE, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            sample(32'(i), 1'b0);
            if (i == 4) expect_val("t1_pre_trig", SEL_STATE, 32'd1);
            if (i == 5) expect_val("t1_post", SEL_STATE, 32'd2);
            if (i == 3) idle_cycle();
        end
        expect_status("t1_end", 2'd3, 1'b1, 4'd7);
        expect_val("t1_tpos", SEL_TPOS, 32'd4);
        rd("t1_rd0", 3'd0, 1'b0, 32'd1);
        rd("t1_rd6", 3'd6, 1'b0, 32'd7);
        rd("t1_rd7_empty", 3'd7, 1'b0, 32'd0);
        rd("t1_rd2_ch1", 3'd2, 1'b1, 32'hA000_0003);

        // Wrap: trigger at sample 20, three post samples, re-armed from DONE.
        do_arm(32'd20, 32'hFFFF_FFFF, 3'd3);
        expect_status("t2_rearm", 2'd1, 1'b0, 4'd0);
        for (int i = 1; i <= 23; i++) begin
            sample(32'(i), 1'b0);
            if (i == 20) expect_val("t2_post", SEL_STATE, 32'd2);
        end
        expect_status("t2_end", 2'd3, 1'b1, 4'd8);
        expect_val("t2_tpos", SEL_TPOS, 32'd4);
        rd("t2_rd0", 3'd0, 1'b0, 32'd16);
        rd("t2_rd7", 3'd7, 1'b0, 32'd23);
        rd("t2_rd3_ch1", 3'd3, 1'b1, 32'hA000_0013);

        // Masked compare: only bits [15:8] participate.
        do_arm(32'h0000_0A00, 32'h0000_FF00, 3'd0);
        sample(32'h1234_0B00, 1'b0);
        expect_val("t3_nomatch", SEL_STATE, 32'd1);
        sample(32'h1234_0A77, 1'b0);
        expect_status("t3_match", 2'd3, 1'b1, 4'd2);
        expect_val("t3_tpos", SEL_TPOS, 32'd1);

        // External trigger on 3rd sample; trig_ext with sample_en low is ignored.
        do_arm(32'h0000_DEAD, 32'hFFFF_FFFF, 3'd0);
        sample(32'd1, 1'b0);
        trig_ext = 1'b1;
        idle_cycle();
        trig_ext = 1'b0;
        sample(32'd2, 1'b0);
        expect_status("t4_mid", 2'd1, 1'b0, 4'd2);
        idle_cycle();
        sample(32'd3, 1'b1);
        expect_status("t4_end", 2'd3, 1'b1, 4'd3);
        expect_val("t4_tpos", SEL_TPOS, 32'd2);
        rd("t4_rd2", 3'd2, 1'b0, 32'd3);

        // Abort from DONE, then arm+abort from IDLE, then abort during POST.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_status("t5_abort_done", 2'd0, 1'b0, 4'd3);
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        expect_val("t5_arm_abort", SEL_STATE, 32'd0);
        do_arm(32'd2, 32'hFFFF_FFFF, 3'd4);
        sample(32'd1, 1'b0);
        sample(32'd2, 1'b0);
        expect_val("t5_in_post", SEL_STATE, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_status("t5_abort_post", 2'd0, 1'b0, 4'd2);

        // Asynchronous reset during POST.
        do_arm(32'd3, 32'hFFFF_FFFF, 3'd4);
        for (int i = 1; i <= 4; i++) sample(32'(i), 1'b0);
        rd("t6_rd0", 3'd0, 1'b0, 32'd1);
        expect_val("t6_post", SEL_STATE, 32'd2);
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        expect_status("t6_async", 2'd0, 1'b0, 4'd0);
        expect_val("t6_async_rd", SEL_RD, 32'd0);
        @(negedge clock);
        #1 reset = 1'b0;

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
